// File: rtl/packet_arbiter.sv
// Round-robin packet arbiter: latches per-source packet requests, grants one source at a
// time and streams wrapped read addresses through its buffer, then inserts an IFG gap.
module packet_arbiter #(
    parameter int unsigned pPORTS      = 4,
    parameter int unsigned pFIFO_WIDTH = 11,
    parameter int unsigned pDEPTH_RAM  = 3072,
    parameter int unsigned pADDR_WIDTH = $clog2(pDEPTH_RAM),
    parameter int unsigned pIFG        = 12
) (
    input  logic                              iclk,
    input  logic                              i_rst,
    input  logic [pPORTS-1:0]                 i_request,
    input  logic [pPORTS*pFIFO_WIDTH-1:0]     i_length,
    input  logic [pPORTS*2-1:0]               i_port_num,
    input  logic [pPORTS*pADDR_WIDTH-1:0]     i_start_adress,
    output logic [pPORTS-1:0]                 o_permition,
    output logic                              o_grant,
    output logic [$clog2(pPORTS)-1:0]         o_grant_src,
    output logic [1:0]                        o_port_num,
    output logic [pFIFO_WIDTH-1:0]            o_length,
    output logic                              o_tx_en,
    output logic [pADDR_WIDTH-1:0]            o_rd_adress,
    output logic                              o_last,
    output logic                              o_drop
);

    localparam int unsigned SRC_W = $clog2(pPORTS);
    localparam int unsigned GAP_W = (pIFG > 1) ? $clog2(pIFG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

    state_t                   state_q, state_d;
    logic [pPORTS-1:0]        pending_q, pending_d;
    logic [pPORTS-1:0]        perm_q, perm_d;
    logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]         sel_q, sel_d;
    logic [SRC_W-1:0]         grant_src_q, grant_src_d;
    logic [1:0]               port_num_q, port_num_d;
    logic [pFIFO_WIDTH-1:0]   length_q, length_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pFIFO_WIDTH-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]         gap_q, gap_d;

    logic [pFIFO_WIDTH-1:0]   len_cap_q   [pPORTS];
    logic [pFIFO_WIDTH-1:0]   len_cap_d   [pPORTS];
    logic [1:0]               dst_cap_q   [pPORTS];
    logic [1:0]               dst_cap_d   [pPORTS];
    logic [pADDR_WIDTH-1:0]   start_cap_q [pPORTS];
    logic [pADDR_WIDTH-1:0]   start_cap_d [pPORTS];

    logic                     found;
    logic [SRC_W-1:0]         pick;
    logic [SRC_W-1:0]         cand;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        grant_src_d = grant_src_q;
        port_num_d  = port_num_q;
        length_d    = length_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        len_cap_d   = len_cap_q;
        dst_cap_d   = dst_cap_q;
        start_cap_d = start_cap_q;
        found       = 1'b0;
        pick        = '0;
        cand        = '0;
        o_grant     = 1'b0;
        o_drop      = 1'b0;
        o_tx_en     = 1'b0;
        o_last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Search starts one past the last granted source.
                for (int unsigned k = 1; k <= pPORTS; k++) begin
                    cand = SRC_W'((32'(rr_ptr_q) + k) % pPORTS);
                    if (!found && pending_q[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    sel_d       = pick;
                    grant_src_d = pick;
                    port_num_d  = dst_cap_q[pick];
                    length_d    = len_cap_q[pick];
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                pending_d[sel_q] = 1'b0;
                rr_ptr_d         = sel_q;
                addr_d           = start_cap_q[sel_q];
                cnt_d            = len_cap_q[sel_q];
                gap_d            = '0;
                if (length_q == '0) begin
                    o_drop  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    o_grant = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                o_tx_en = 1'b1;
                addr_d  = (addr_q == pADDR_WIDTH'(pDEPTH_RAM - 1)) ? '0 : addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == pFIFO_WIDTH'(1)) begin
                    o_last  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(pIFG - 1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Applied after the grant clear so a same-cycle request wins.
        for (int unsigned i = 0; i < pPORTS; i++) begin
            if (i_request[i]) begin
                pending_d[i]   = 1'b1;
                len_cap_d[i]   = i_length[i*pFIFO_WIDTH +: pFIFO_WIDTH];
                dst_cap_d[i]   = i_port_num[i*2 +: 2];
                start_cap_d[i] = i_start_adress[i*pADDR_WIDTH +: pADDR_WIDTH];
            end
        end
        perm_d = ~pending_d;

        o_rd_adress = o_tx_en ? addr_q : '0;
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            perm_q      <= '1;
            rr_ptr_q    <= SRC_W'(pPORTS - 1);
            sel_q       <= '0;
            grant_src_q <= '0;
            port_num_q  <= '0;
            length_q    <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            for (int unsigned i = 0; i < pPORTS; i++) begin
                len_cap_q[i]   <= '0;
                dst_cap_q[i]   <= '0;
                start_cap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            perm_q      <= perm_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            grant_src_q <= grant_src_d;
            port_num_q  <= port_num_d;
            length_q    <= length_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            len_cap_q   <= len_cap_d;
            dst_cap_q   <= dst_cap_d;
            start_cap_q <= start_cap_d;
        end
    end

    assign o_permition = perm_q;
    assign o_grant_src = grant_src_q;
    assign o_port_num  = port_num_q;
    assign o_length    = length_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed self-checking bench for packet_arbiter: grant timing, address wrap,
// round-robin order, zero-length drop, gap spacing and mid-packet reset.
module tb_packet_arbiter;

    localparam int P  = 4;
    localparam int FW = 11;
    localparam int AW = 12;

    logic            iclk = 1'b0;
    logic            i_rst;
    logic [P-1:0]    i_request;
    logic [P*FW-1:0] i_length;
    logic [P*2-1:0]  i_port_num;
    logic [P*AW-1:0] i_start_adress;
    logic [P-1:0]    o_permition;
    logic            o_grant;
    logic [1:0]      o_grant_src;
    logic [1:0]      o_port_num;
    logic [FW-1:0]   o_length;
    logic            o_tx_en;
    logic [AW-1:0]   o_rd_adress;
    logic            o_last;
    logic            o_drop;

    int tests_run    = 0;
    int tests_failed = 0;

    packet_arbiter #(
        .pPORTS      (4),
        .pFIFO_WIDTH (11),
        .pDEPTH_RAM  (3072),
        .pADDR_WIDTH (12),
        .pIFG        (12)
    ) dut (
        .iclk           (iclk),
        .i_rst          (i_rst),
        .i_request      (i_request),
        .i_length       (i_length),
        .i_port_num     (i_port_num),
        .i_start_adress (i_start_adress),
        .o_permition    (o_permition),
        .o_grant        (o_grant),
        .o_grant_src    (o_grant_src),
        .o_port_num     (o_port_num),
        .o_length       (o_length),
        .o_tx_en        (o_tx_en),
        .o_rd_adress    (o_rd_adress),
        .o_last         (o_last),
        .o_drop         (o_drop)
    );

    always #5 iclk = ~iclk;

    task automatic step;
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset;
        i_rst          = 1'b1;
        i_request      = '0;
        i_length       = '0;
        i_port_num     = '0;
        i_start_adress = '0;
        step;
        step;
        i_rst = 1'b0;
    endtask

    task automatic set_req(input int p, input int len, input int dst, input int start);
        i_request[p]              = 1'b1;
        i_length[p*FW +: FW]      = FW'(len);
        i_port_num[p*2 +: 2]      = 2'(dst);
        i_start_adress[p*AW +: AW] = AW'(start);
    endtask

    task automatic wait_grant(input int max_cyc, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < max_cyc) begin
            step;
            cyc++;
            if (o_grant === 1'b1 || o_drop === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        tests_run++;
        if (o_permition !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_perm: got %b expected 1111", o_permition);
        end
        tests_run++;
        if ({o_grant, o_tx_en, o_last, o_drop} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 0000", {o_grant, o_tx_en, o_last, o_drop});
        end
        tests_run++;
        if (o_grant_src !== 2'd0 || o_port_num !== 2'd0 || o_length !== 11'd0 || o_rd_adress !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_fields: got src=%0d port=%0d len=%0d addr=%0d expected all 0",
                     o_grant_src, o_port_num, o_length, o_rd_adress);
        end
    endtask

    task automatic test_single;
        do_reset;
        set_req(2, 64, 3, 100);
        step;
        i_request = '0;
        tests_run++;
        if (o_permition !== 4'b1011) begin
            tests_failed++;
            $display("FAIL single_perm_fall: got %b expected 1011", o_permition);
        end
        step;
        tests_run++;
        if (o_grant !== 1'b1 || o_grant_src !== 2'd2 || o_port_num !== 2'd3 || o_length !== 11'd64) begin
            tests_failed++;
            $display("FAIL single_grant: got g=%0d src=%0d port=%0d len=%0d expected 1 2 3 64",
                     o_grant, o_grant_src, o_port_num, o_length);
        end
        step;
        tests_run++;
        if (o_permition !== 4'hF) begin
            tests_failed++;
            $display("FAIL single_perm_rise: got %b expected 1111", o_permition);
        end
        for (int k = 0; k < 64; k++) begin
            tests_run++;
            if (o_tx_en !== 1'b1 || o_rd_adress !== AW'(100 + k) || o_last !== (k == 63)) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got en=%0d addr=%0d last=%0d expected 1 %0d %0d",
                         k, o_tx_en, o_rd_adress, o_last, 100 + k, (k == 63));
            end
            step;
        end
        for (int g = 0; g < 12; g++) begin
            tests_run++;
            if (o_tx_en !== 1'b0 || o_grant !== 1'b0 || o_last !== 1'b0 || o_grant_src !== 2'd2) begin
                tests_failed++;
                $display("FAIL single_gap%0d: got en=%0d g=%0d last=%0d src=%0d expected 0 0 0 2",
                         g, o_tx_en, o_grant, o_last, o_grant_src);
            end
            step;
        end
    endtask

    task automatic test_wrap;
        int exp_addr;
        do_reset;
        set_req(1, 20, 0, 3060);
        step;
        i_request = '0;
        step;
        tests_run++;
        if (o_grant !== 1'b1 || o_grant_src !== 2'd1) begin
            tests_failed++;
            $display("FAIL wrap_grant: got g=%0d src=%0d expected 1 1", o_grant, o_grant_src);
        end
        step;
        for (int k = 0; k < 20; k++) begin
            exp_addr = 3060 + k;
            if (exp_addr >= 3072) exp_addr = exp_addr - 3072;
            tests_run++;
            if (o_tx_en !== 1'b1 || o_rd_adress !== AW'(exp_addr) || o_last !== (k == 19)) begin
                tests_failed++;
                $display("FAIL wrap_byte%0d: got en=%0d addr=%0d last=%0d expected 1 %0d %0d",
                         k, o_tx_en, o_rd_adress, o_last, exp_addr, (k == 19));
            end
            step;
        end
        tests_run++;
        if (o_tx_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: got en=%0d expected 0", o_tx_en);
        end
    endtask

    task automatic test_all_ports;
        bit ok;
        int cyc;
        do_reset;
        for (int p = 0; p < 4; p++) set_req(p, 2, p, p * 10);
        step;
        i_request = '0;
        tests_run++;
        if (o_permition !== 4'b0000) begin
            tests_failed++;
            $display("FAIL all_perm_fall: got %b expected 0000", o_permition);
        end
        for (int j = 0; j < 4; j++) begin
            wait_grant(40, ok, cyc);
            tests_run++;
            if (!ok || o_grant_src !== 2'(j) || o_port_num !== 2'(j) || cyc !== ((j == 0) ? 1 : 16)) begin
                tests_failed++;
                $display("FAIL all_grant%0d: got ok=%0d src=%0d port=%0d after %0d cycles expected 1 %0d %0d after %0d",
                         j, ok, o_grant_src, o_port_num, cyc, j, j, (j == 0) ? 1 : 16);
            end
            tests_run++;
            if (o_permition !== 4'((1 << j) - 1)) begin
                tests_failed++;
                $display("FAIL all_perm%0d: got %b expected %b", j, o_permition, 4'((1 << j) - 1));
            end
        end
    endtask

    task automatic test_fairness;
        bit ok;
        int cyc;
        do_reset;
        set_req(1, 4, 1, 0);
        set_req(3, 4, 2, 200);
        step;
        i_request = '0;
        wait_grant(10, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd1) begin
            tests_failed++;
            $display("FAIL rr_first: got ok=%0d src=%0d expected 1 1", ok, o_grant_src);
        end
        step;
        tests_run++;
        if (o_permition !== 4'b0111) begin
            tests_failed++;
            $display("FAIL rr_perm: got %b expected 0111", o_permition);
        end
        set_req(1, 4, 1, 50);
        step;
        i_request = '0;
        wait_grant(40, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd3 || o_port_num !== 2'd2) begin
            tests_failed++;
            $display("FAIL rr_second: got ok=%0d src=%0d port=%0d expected 1 3 2", ok, o_grant_src, o_port_num);
        end
        wait_grant(40, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd1 || cyc !== 18) begin
            tests_failed++;
            $display("FAIL rr_third: got ok=%0d src=%0d after %0d cycles expected 1 1 after 18", ok, o_grant_src, cyc);
        end
        step;
        tests_run++;
        if (o_rd_adress !== 12'd50 || o_tx_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_third_addr: got en=%0d addr=%0d expected 1 50", o_tx_en, o_rd_adress);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int cyc;
        do_reset;
        set_req(0, 5, 0, 10);
        set_req(1, 3, 1, 20);
        step;
        i_request = '0;
        wait_grant(10, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd0 || o_length !== 11'd5) begin
            tests_failed++;
            $display("FAIL b2b_first: got ok=%0d src=%0d len=%0d expected 1 0 5", ok, o_grant_src, o_length);
        end
        wait_grant(40, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd1 || o_length !== 11'd3 || cyc !== 19) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got ok=%0d src=%0d len=%0d after %0d cycles expected 1 1 3 after 19",
                     ok, o_grant_src, o_length, cyc);
        end
    endtask

    task automatic test_zero_length;
        bit ok;
        int cyc;
        bit saw_tx;
        bit got;
        do_reset;
        set_req(0, 0, 2, 30);
        set_req(1, 3, 1, 40);
        step;
        i_request = '0;
        wait_grant(10, ok, cyc);
        tests_run++;
        if (!ok || o_drop !== 1'b1 || o_grant !== 1'b0 || o_tx_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_drop: got ok=%0d drop=%0d g=%0d en=%0d expected 1 1 0 0", ok, o_drop, o_grant, o_tx_en);
        end
        saw_tx = 1'b0;
        got    = 1'b0;
        cyc    = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            step;
            if (i == 1) begin
                tests_run++;
                if (o_permition !== 4'b1101 || o_drop !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL zero_perm: got perm=%b drop=%0d expected 1101 0", o_permition, o_drop);
                end
            end
            if (o_grant === 1'b1) begin
                got = 1'b1;
                cyc = i;
            end else if (o_tx_en !== 1'b0) begin
                saw_tx = 1'b1;
            end
        end
        tests_run++;
        if (!got || saw_tx || cyc !== 14 || o_grant_src !== 2'd1) begin
            tests_failed++;
            $display("FAIL zero_next: got grant=%0d tx_seen=%0d after %0d cycles src=%0d expected 1 0 after 14 src 1",
                     got, saw_tx, cyc, o_grant_src);
        end
    endtask

    task automatic test_reset_mid_packet;
        bit ok;
        int cyc;
        bit stray;
        do_reset;
        set_req(2, 100, 1, 0);
        step;
        i_request = '0;
        wait_grant(10, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd2) begin
            tests_failed++;
            $display("FAIL mid_grant: got ok=%0d src=%0d expected 1 2", ok, o_grant_src);
        end
        step;
        set_req(3, 5, 1, 0);
        step;
        i_request = '0;
        for (int b = 1; b < 40; b++) step;
        tests_run++;
        if (o_tx_en !== 1'b1 || o_rd_adress !== 12'd40) begin
            tests_failed++;
            $display("FAIL mid_byte40: got en=%0d addr=%0d expected 1 40", o_tx_en, o_rd_adress);
        end
        i_rst = 1'b1;
        step;
        tests_run++;
        if (o_tx_en !== 1'b0 || o_last !== 1'b0 || o_permition !== 4'hF) begin
            tests_failed++;
            $display("FAIL mid_rst_out: got en=%0d last=%0d perm=%b expected 0 0 1111", o_tx_en, o_last, o_permition);
        end
        tests_run++;
        if (o_grant_src !== 2'd0 || o_length !== 11'd0 || o_port_num !== 2'd0 || o_rd_adress !== 12'd0) begin
            tests_failed++;
            $display("FAIL mid_rst_fields: got src=%0d len=%0d port=%0d addr=%0d expected all 0",
                     o_grant_src, o_length, o_port_num, o_rd_adress);
        end
        i_rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (o_grant !== 1'b0 || o_drop !== 1'b0 || o_tx_en !== 1'b0) stray = 1'b1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL mid_pending_cleared: got activity=1 expected 0");
        end
        set_req(0, 4, 0, 0);
        set_req(3, 4, 3, 0);
        step;
        i_request = '0;
        wait_grant(10, ok, cyc);
        tests_run++;
        if (!ok || o_grant_src !== 2'd0 || cyc !== 1) begin
            tests_failed++;
            $display("FAIL mid_first_after: got ok=%0d src=%0d after %0d expected 1 0 after 1", ok, o_grant_src, cyc);
        end
    endtask

    initial begin
        i_rst          = 1'b1;
        i_request      = '0;
        i_length       = '0;
        i_port_num     = '0;
        i_start_adress = '0;
        test_reset;
        test_single;
        test_wrap;
        test_all_ports;
        test_fairness;
        test_back_to_back;
        test_zero_length;
        test_reset_mid_packet;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Round-robin arbiter downstream of the per-port pre-arbiters. Latches each port's one-cycle packet request (length, destination port, start address), grants one source at a time, then streams read addresses through the source's packet buffer for exactly `length` cycles with address wrap-around. It also returns the per-port write permission that paces each pre-arbiter.

## Interface
- `pPORTS`, 4: number of source ports/pre-arbiters (≥2).
- `pFIFO_WIDTH`, 11: width of a packet length.
- `pDEPTH_RAM`, 3072: packet buffer depth in bytes; address wrap modulus.
- `pADDR_WIDTH`, $clog2(pDEPTH_RAM): buffer address width.
- `pIFG`, 12: idle cycles inserted after each packet (≥1).
- `iclk` in 1: single clock; all logic on posedge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_request` in pPORTS: bit i is a one-cycle request pulse from source i.
- `i_length` in pPORTS*pFIFO_WIDTH: source i length in slice [i*pFIFO_WIDTH +: pFIFO_WIDTH]; valid with request.
- `i_port_num` in pPORTS*2: destination port per source; valid with request.
- `i_start_adress` in pPORTS*pADDR_WIDTH: packet start address per source; valid with request.
- `o_permition` out pPORTS: bit i = source i may raise a new request.
- `o_grant` out 1: one-cycle grant strobe.
- `o_grant_src` out $clog2(pPORTS): granted source index.
- `o_port_num` out 2: destination of the granted packet.
- `o_length` out pFIFO_WIDTH: length of the granted packet.
- `o_tx_en` out 1: read-address valid.
- `o_rd_adress` out pADDR_WIDTH: byte read address into the granted source's buffer.
- `o_last` out 1: marks the final byte of the packet.
- `o_drop` out 1: one-cycle pulse when a zero-length request is discarded.

## Operation
- Per source i, on `i_request[i]`: set `pending[i]` and capture length, destination and start address into per-source registers.
- `o_permition[i] = ~pending[i]`, registered. A source cannot re-request while pending.
- If a request and a clear hit the same source in the same cycle, the set wins.
- State machine: IDLE, GRANT, XFER, GAP.
- IDLE: if any `pending` bit is set, choose a source by round-robin and go to GRANT.
  - Search order is `rr_ptr+1`, `rr_ptr+2`, … modulo pPORTS.
  - `rr_ptr` is the last granted source; reset value pPORTS-1, so port 0 has first priority.
- GRANT, one cycle:
  - Drive `o_grant=1` and `o_grant_src`, `o_port_num`, `o_length` from the captured registers.
  - Clear `pending[src]` and set `rr_ptr=src`.
  - Load `addr=start` and `cnt=length`.
  - If length==0: pulse `o_drop` instead of `o_grant` and go to GAP. Otherwise go to XFER.
- XFER:
  - Drive `o_tx_en=1`, `o_rd_adress=addr`.
  - Each cycle: `addr = (addr==pDEPTH_RAM-1) ? 0 : addr+1` and `cnt` decrements.
  - `o_last=1` when `cnt==1`; the next state is then GAP.
- GAP: count pIFG cycles with `o_tx_en=0`, then go to IDLE.
- `o_port_num`, `o_length` and `o_grant_src` hold their values from GRANT until the next GRANT.
- Address arithmetic is pADDR_WIDTH wide, and wrap uses an explicit compare to pDEPTH_RAM-1 (the depth need not be a power of 2). Length is unsigned.

## Timing
- Reset values:
  - `o_permition` all 1.
  - `o_grant`, `o_tx_en`, `o_last`, `o_drop` = 0.
  - `o_grant_src`, `o_port_num`, `o_length`, `o_rd_adress` = 0.
  - State IDLE, `pending`=0, `rr_ptr`=pPORTS-1.
- Request pulse at cycle N:
  - `pending` is set and `o_permition[i]` falls at N+1.
  - If the arbiter is IDLE, GRANT occurs at N+2 and the first `o_tx_en` at N+3.
  - `o_permition[i]` rises at the GRANT+1 edge.
- A packet of length L occupies GRANT(1) + XFER(L) + GAP(pIFG) cycles. Back-to-back grants are spaced L+pIFG+2 cycles apart (IDLE takes 1 cycle).
- Requests arriving during GRANT, XFER or GAP are latched and served in round-robin order. None is lost.
- Reset asserted mid-packet: all outputs return to their reset values on the next edge, and any in-flight transfer is abandoned with no `o_last`.

## Test plan
- Single request, port 2, length 64, start 100 → `o_grant` with src=2 at N+2; addresses 100..163 on `o_tx_en`; `o_last` on 163; then 12 idle cycles.
- Wrap: start 3060, length 20 → addresses 3060..3071, then 0..7; `o_last` on address 7.
- All 4 ports request in the same cycle after reset → grant order 0,1,2,3. Each `o_permition` rises only after its own grant.
- Port 1 requests again immediately after its grant while port 3 is pending → order 1, 3, 1 (round-robin fairness).
- Zero-length request on port 0 → `o_drop` pulse, no `o_tx_en`, `o_permition[0]` restored, next packet granted after pIFG.
- `i_rst` asserted during XFER of a 100-byte packet at byte 40 → next cycle `o_tx_en=0`, `o_permition`=1111, `pending`=0. The first grant after release is port 0.
